// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type and bus-level constants for the I2C slave
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: synchronise, glitch-filter and edge-detect one open-drain line
module i2c_line_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  logic s1, s2, prev;
  logic [CW-1:0] cnt;
  // two-flop sync, then accept a new level only after FILTER_LEN equal samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      prev <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= line_in;
      s2 <= s1;
      prev <= level;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: single-address I2C slave turning bus traffic into byte streams
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oen,
  input  logic [7:0] write_data,
  input  logic       write_en,
  output logic       write_rdy,
  output logic [7:0] read_data,
  output logic       read_en,
  output logic       hitar,
  output logic       flag_start,
  output logic       flag_restart,
  output logic       flag_ack,
  output logic       flag_stop,
  output logic       flag_err
);
  state_t state, state_n;
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start_c, stop_c, match, ld, rw, buf_full;
  logic [3:0] bit_cnt;
  logic [7:0] shift, tx_buf, tx_src;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst_n(rst_n), .line_in(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst_n(rst_n), .line_in(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_c = sda_fall & scl;
  assign stop_c = sda_rise & scl;
  assign match = shift[6:0] == SLAVE_ADDR;
  assign tx_src = buf_full ? tx_buf : 8'hFF;
  assign ld = scl_fall & ((state == ADDR_ACK & ~sda_oen & rw == RW_READ) |
                          (state == RD_ACK & bit_cnt == 4'd9));

  // protocol state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next state: bus conditions override per-bit progress
  always_comb begin
    state_n = state;
    case (state)
      ADDR:     if (scl_rise && bit_cnt == 4'd7) state_n = match ? ADDR_ACK : WAIT_STOP;
      ADDR_ACK: if (scl_fall && !sda_oen) state_n = rw == RW_READ ? RD_BYTE : WR_BYTE;
      WR_BYTE:  if (scl_rise && bit_cnt == 4'd7) state_n = WR_ACK;
      WR_ACK:   if (scl_fall && !sda_oen) state_n = WR_BYTE;
      RD_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_n = RD_ACK;
      RD_ACK:   if (scl_rise && sda != ACK) state_n = WAIT_STOP;
                else if (ld) state_n = RD_BYTE;
      default: ;
    endcase
    if (start_c) state_n = ADDR;
    if (stop_c) state_n = IDLE;
  end

  // shifter, SDA drive, transmit buffer and status pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sda_oen <= 1'b1;
      write_rdy <= 1'b0;
      read_data <= '0;
      read_en <= 1'b0;
      hitar <= 1'b0;
      flag_start <= 1'b0;
      flag_restart <= 1'b0;
      flag_ack <= 1'b0;
      flag_stop <= 1'b0;
      flag_err <= 1'b0;
      bit_cnt <= '0;
      shift <= '0;
      tx_buf <= '0;
      buf_full <= 1'b0;
      rw <= RW_WRITE;
    end else begin
      read_en <= 1'b0;
      hitar <= 1'b0;
      flag_start <= 1'b0;
      flag_restart <= 1'b0;
      flag_ack <= 1'b0;
      flag_stop <= 1'b0;
      flag_err <= 1'b0;
      if (stop_c) begin
        flag_stop <= 1'b1;
        sda_oen <= 1'b1;
        write_rdy <= 1'b0;
      end else if (start_c) begin
        flag_start <= 1'b1;
        flag_restart <= state != IDLE;
        sda_oen <= 1'b1;
        write_rdy <= 1'b0;
        buf_full <= 1'b0;
        bit_cnt <= '0;
      end else if (ld) begin
        shift <= {tx_src[6:0], 1'b1};
        sda_oen <= tx_src[7];
        flag_err <= ~buf_full;
        buf_full <= 1'b0;
        bit_cnt <= 4'd1;
      end else
        case (state)
          ADDR, WR_BYTE:
            if (scl_rise) begin
              shift <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && state == ADDR) begin
                rw <= sda;
                hitar <= match;
                flag_err <= ~match;
              end
              if (bit_cnt == 4'd7 && state == WR_BYTE) begin
                read_data <= {shift[6:0], sda};
                read_en <= 1'b1;
              end
            end
          ADDR_ACK, WR_ACK:
            if (scl_fall) begin
              sda_oen <= ~sda_oen;
              bit_cnt <= '0;
              if (sda_oen && state == ADDR_ACK) write_rdy <= rw == RW_READ;
            end
          RD_BYTE:
            if (scl_fall) begin
              sda_oen <= bit_cnt == 4'd8 ? 1'b1 : shift[7];
              if (bit_cnt != 4'd8) begin
                shift <= {shift[6:0], 1'b1};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          RD_ACK:
            if (scl_rise) begin
              flag_ack <= sda == ACK;
              write_rdy <= sda == ACK;
              bit_cnt <= sda == ACK ? 4'd9 : bit_cnt;
            end
          default: ;
        endcase
      if (write_en) begin
        tx_buf <= write_data;
        buf_full <= 1'b1;
        write_rdy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: directed I2C master transactions against the slave core
module tb_i2c_slave_core;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, write_en = 1'b0;
  logic [7:0] write_data = '0;
  logic sda_oen, write_rdy, read_en, hitar, flag_start, flag_restart, flag_ack, flag_stop, flag_err;
  logic [7:0] read_data;
  logic sda_line;
  int n_chk = 0, n_pass = 0;
  int c_start, c_restart, c_stop, c_err, c_ack, c_hit;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign sda_line = sda_m & sda_oen;

  i2c_slave_core dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line), .sda_oen(sda_oen),
    .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
    .read_data(read_data), .read_en(read_en), .hitar(hitar),
    .flag_start(flag_start), .flag_restart(flag_restart), .flag_ack(flag_ack),
    .flag_stop(flag_stop), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      c_start += int'(flag_start);
      c_restart += int'(flag_restart);
      c_stop += int'(flag_stop);
      c_err += int'(flag_err);
      c_ack += int'(flag_ack);
      c_hit += int'(hitar);
      if (read_en) rx_q.push_back(read_data);
    end

  initial forever begin
    @(negedge clk);
    if (write_en) write_en = 1'b0;
    else if (write_rdy && tx_q.size() > 0) begin
      write_data = tx_q.pop_front();
      write_en = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clr();
    c_start = 0; c_restart = 0; c_stop = 0; c_err = 0; c_ack = 0; c_hit = 0;
    rx_q.delete();
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic nak);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, nak);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic last);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
    bit_io(last, r);
  endtask

  initial begin
    logic n0, n1, n2, nk;
    logic [7:0] d;
    logic [7:0] t3[8] = '{8'hA0, 8'hB2, 8'hCD, 8'hEF, 8'hCC, 8'hA0, 8'hB0, 8'hC0};
    logic [7:0] t4[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clr();
    repeat (3) @(negedge clk);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_write_rdy", write_rdy, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_flags", {read_en, hitar, flag_start, flag_restart, flag_ack, flag_stop, flag_err}, 0);
    rst_n = 1'b1;
    wait_q();

    clr();
    i2c_start();
    wr_byte(8'hA0, n0); wr_byte(8'h01, n1); wr_byte(8'h02, n2);
    i2c_stop();
    chk("t1_start", c_start, 1);
    chk("t1_hitar", c_hit, 1);
    chk("t1_acks", {n0, n1, n2}, 0);
    chk("t1_rx_cnt", rx_q.size(), 2);
    chk("t1_rx0", rx_q[0], 8'h01);
    chk("t1_rx1", rx_q[1], 8'h02);
    chk("t1_stop", c_stop, 1);
    chk("t1_err", c_err, 0);

    clr();
    i2c_start();
    wr_byte(8'hB0, n0); wr_byte(8'h01, n1); wr_byte(8'h02, n2);
    chk("t2_addr_nack", n0, 1);
    chk("t2_err", c_err, 1);
    chk("t2_hitar", c_hit, 0);
    chk("t2_no_rx", rx_q.size(), 0);
    i2c_start();
    wr_byte(8'hA0, n0);
    i2c_stop();
    chk("t2_recover_ack", n0, 0);
    chk("t2_recover_hit", c_hit, 1);
    chk("t2_restart", c_restart, 1);

    clr();
    i2c_start();
    wr_byte(8'hA0, n0);
    nk = n0;
    for (int i = 0; i < 8; i++) begin
      wr_byte(t3[i], n1);
      nk |= n1;
    end
    i2c_stop();
    chk("t3_acks", nk, 0);
    chk("t3_rx_cnt", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_rx%0d", i), rx_q[i], t3[i]);

    clr();
    for (int i = 0; i < 5; i++) tx_q.push_back(t4[i]);
    i2c_start();
    wr_byte(8'hA1, n0);
    chk("t4_addr_ack", n0, 0);
    for (int i = 0; i < 5; i++) begin
      rd_byte(d, i == 4);
      chk($sformatf("t4_tx%0d", i), d, t4[i]);
    end
    i2c_stop();
    chk("t4_flag_ack", c_ack, 4);
    chk("t4_err", c_err, 0);
    chk("t4_stop", c_stop, 1);
    chk("t4_write_rdy", write_rdy, 0);
    chk("t4_tx_left", tx_q.size(), 0);

    clr();
    i2c_start();
    wr_byte(8'hA0, n0); wr_byte(8'h12, n1);
    tx_q.push_back(8'hDB);
    i2c_start();
    wr_byte(8'hA1, n2);
    rd_byte(d, 1'b1);
    i2c_stop();
    chk("t5_acks", {n0, n1, n2}, 0);
    chk("t5_rx_cnt", rx_q.size(), 1);
    chk("t5_rx0", rx_q[0], 8'h12);
    chk("t5_restart", c_restart, 1);
    chk("t5_start", c_start, 2);
    chk("t5_tx", d, 8'hDB);
    chk("t5_stop", c_stop, 1);

    clr();
    i2c_start();
    wr_byte(8'hA1, n0);
    rd_byte(d, 1'b1);
    i2c_stop();
    chk("t6_underrun_err", c_err, 1);
    chk("t6_underrun_data", d, 8'hFF);
    tx_q.push_back(8'h00);
    i2c_start();
    wr_byte(8'hA1, n0);
    for (int i = 0; i < 3; i++) bit_io(1'b1, n1);
    chk("t6_driving_low", sda_oen, 0);
    #1 rst_n = 1'b0;
    #1 chk("t6_async_release", sda_oen, 1);
    chk("t6_rst_read_data", read_data, 0);
    chk("t6_rst_write_rdy", write_rdy, 0);
    @(negedge clk) rst_n = 1'b1;
    i2c_stop();
    clr();
    i2c_start();
    wr_byte(8'hA0, n0); wr_byte(8'h5A, n1);
    i2c_stop();
    chk("t6_post_rst_acks", {n0, n1}, 0);
    chk("t6_post_rst_rx", rx_q[0], 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
